display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters, one per line (name, default, meaning):
- ANODES, 10, number of multiplexed anode positions; ≥2.
- GROUPS, 2, cathode groups driven per anode position.
- DIGIT_W, 4, bits per digit.
- DWELL, 3, Tick pulses a digit stays lit.
- BLANK_LZ, 0, 1 = leading-zero blanking enabled.
- READY_TO, 255, Clk cycles to wait for Ready before timeout.
REQ-003 Ports, one per line (name, direction, width, meaning):
- Clk, in, 1, system clock.
- Rst, in, 1, async active-high reset.
- Tick, in, 1, single-Clk scan pulse.
- Enable, in, 1, scanning permitted.
- Data, in, ANODES*GROUPS*DIGIT_W, digit k/group g at bits [(k*GROUPS+g)*DIGIT_W +: DIGIT_W].
- Ready, in, 1, external latch accepted last strobe.
- AnodeIdx, out, clog2(ANODES), current anode index.
- AnodeSel, out, ANODES, one-hot of AnodeIdx.
- CathodeData, out, GROUPS*DIGIT_W, digits for current anode.
- Clear, out, 1, clear strobe.
- WriteAnode, out, 1, anode latch strobe.
- WriteCathode, out, 1, cathode latch strobe.
- FrameStart, out, 1, pulse at frame snapshot.
- Busy, out, 1, state not IDLE.
- Error, out, 1, sticky Ready-timeout flag.

Function
REQ-004 All outputs SHALL be registered.
REQ-005 The FSM SHALL have these states: IDLE, CLR, CLR_W, ANO, ANO_W, CAT, CAT_W, DWELL.
REQ-006 In IDLE, with Enable=1 and Tick=1, the FSM SHALL go to CLR on the next Clk; otherwise it SHALL stay in IDLE.
REQ-007 On leaving IDLE with AnodeIdx=0, the block SHALL copy Data into a shadow register and pulse FrameStart for 1 cycle; at any other index the shadow SHALL be unchanged, so a frame is never torn.
REQ-008 Clear, WriteAnode and WriteCathode SHALL each be high for exactly 1 cycle, in states CLR, ANO and CAT respectively; at most one strobe SHALL be high in any cycle.
REQ-009 Each *_W state SHALL advance (CLR_W→ANO, ANO_W→CAT, CAT_W→DWELL) on the first cycle Ready=1, checked from the cycle after the strobe onward.
REQ-010 If Ready stays 0 for READY_TO cycles in a *_W state, the block SHALL set Error and advance as if Ready=1.
REQ-011 Error SHALL be cleared only by Rst.
REQ-012 CathodeData SHALL be updated from the shadow for AnodeIdx in the ANO cycle, and SHALL be stable through CAT and DWELL.
REQ-013 DWELL SHALL count Tick pulses; on the DWELL-th Tick, AnodeIdx SHALL increment, wrapping ANODES-1→0, and the FSM SHALL return to IDLE.
REQ-014 AnodeSel SHALL update in the same cycle as AnodeIdx.
REQ-015 With BLANK_LZ=1, per group, digits at the highest indices equal to 0, down to the first nonzero digit, SHALL output all-ones (blank); index 0 SHALL never be blanked.
REQ-016 Blanking SHALL be evaluated on the shadow.
REQ-017 Digit values above 9 SHALL pass through unchanged.
REQ-018 If Enable falls mid-sequence, the current digit SHALL complete through DWELL; the FSM SHALL then hold in IDLE with AnodeIdx retained.
REQ-019 A Tick arriving in any state other than IDLE or DWELL SHALL be ignored.

Reset
REQ-020 On Rst: state IDLE, AnodeIdx=0, AnodeSel=1, CathodeData=0, shadow=0, all strobes 0, FrameStart=0, Busy=0, Error=0, dwell counter=0, timeout counter=0.
REQ-021 Rst asserted mid-sequence SHALL abort immediately; no strobe SHALL follow until a new Enable&Tick.

Verification
REQ-022 Default parameters, Ready tied 1, Enable=1, Tick every 8 cycles, Data digit k = k -> per-digit strobe order Clear, WriteAnode, WriteCathode; AnodeIdx 0..9 then 0; group-0 CathodeData nibble = k; FrameStart only at idx 0.
REQ-023 Data changed while AnodeIdx=4 -> displayed digits 4..9 keep old values; new values appear from the next FrameStart.
REQ-024 BLANK_LZ=1, group-0 digits 9..0 = 0,0,0,7,0,0,0,0,0,0 -> digits 9..7 output 4'hF, digit 6 = 7, digits 5..0 = 0; all-zero group shows 4'hF on digits 9..1 and 0 on digit 0.
REQ-025 Ready held 0 after WriteAnode -> exactly READY_TO cycles in ANO_W, then Error=1, CAT entered; Error stays 1 until Rst.
REQ-026 Enable dropped during ANO_W at idx 3 -> sequence completes, AnodeIdx becomes 4, Busy=0, no further strobes until Enable returns.
REQ-027 Rst pulsed during CAT_W -> outputs at reset values in the same cycle; after release, the next Enable&Tick starts at idx 0 with FrameStart.

Source files
------------

// File: rtl/display_scanner.sv
// Multiplexed display scanner: snapshots a frame, then walks the anodes issuing
// clear / anode / cathode latch strobes with Ready handshakes and a per-digit dwell.
module display_scanner #(
    parameter int ANODES   = 10,
    parameter int GROUPS   = 2,
    parameter int DIGIT_W  = 4,
    parameter int DWELL    = 3,
    parameter int BLANK_LZ = 0,
    parameter int READY_TO = 255
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                Tick,
    input  logic                                Enable,
    input  logic [ANODES*GROUPS*DIGIT_W-1:0]    Data,
    input  logic                                Ready,
    output logic [$clog2(ANODES)-1:0]           AnodeIdx,
    output logic [ANODES-1:0]                   AnodeSel,
    output logic [GROUPS*DIGIT_W-1:0]           CathodeData,
    output logic                                Clear,
    output logic                                WriteAnode,
    output logic                                WriteCathode,
    output logic                                FrameStart,
    output logic                                Busy,
    output logic                                Error
);
    localparam int IDX_W = $clog2(ANODES);
    localparam int GW    = GROUPS * DIGIT_W;
    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int TO_W  = $clog2(READY_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_CLR_W, S_ANO, S_ANO_W, S_CAT, S_CAT_W, S_DWELL
    } state_t;

    state_t                     state, next_state;
    logic [ANODES-1:0][GW-1:0]  shadow, disp;
    logic [DW_W-1:0]            dwell_cnt;
    logic [TO_W-1:0]            to_cnt;
    logic                       in_wait, timeout, advance, dwell_done, last_idx;
    logic                       clear_d, wa_d, wc_d, fs_d, busy_d, error_d, snap, load_cath;
    logic [IDX_W-1:0]           idx_d;

    // Per group, zeros above the most significant nonzero digit become all-ones.
    function automatic logic [ANODES-1:0][GW-1:0] blank_lead(input logic [ANODES-1:0][GW-1:0] s);
        logic [ANODES-1:0][GW-1:0] r;
        logic lead;
        r = s;
        for (int g = 0; g < GROUPS; g++) begin
            lead = 1'b1;
            for (int k = ANODES - 1; k > 0; k--) begin
                if (lead && s[k][g*DIGIT_W +: DIGIT_W] == '0)
                    r[k][g*DIGIT_W +: DIGIT_W] = '1;
                else
                    lead = 1'b0;
            end
        end
        return r;
    endfunction

    always_comb begin
        disp = (BLANK_LZ != 0) ? blank_lead(shadow) : shadow;
    end

    assign in_wait    = (state == S_CLR_W) || (state == S_ANO_W) || (state == S_CAT_W);
    assign timeout    = in_wait && !Ready && (to_cnt == TO_W'(READY_TO - 1));
    assign advance    = Ready || timeout;
    assign dwell_done = Tick && (dwell_cnt == DW_W'(DWELL - 1));
    assign last_idx   = (AnodeIdx == IDX_W'(ANODES - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (Enable && Tick) next_state = S_CLR;
            S_CLR:   next_state = S_CLR_W;
            S_CLR_W: if (advance) next_state = S_ANO;
            S_ANO:   next_state = S_ANO_W;
            S_ANO_W: if (advance) next_state = S_CAT;
            S_CAT:   next_state = S_CAT_W;
            S_CAT_W: if (advance) next_state = S_DWELL;
            S_DWELL: if (dwell_done) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so their registers line up with the state.
    always_comb begin
        clear_d   = (next_state == S_CLR);
        wa_d      = (next_state == S_ANO);
        wc_d      = (next_state == S_CAT);
        busy_d    = (next_state != S_IDLE);
        snap      = (state == S_IDLE) && (next_state == S_CLR) && (AnodeIdx == '0);
        fs_d      = snap;
        load_cath = (state == S_CLR_W) && (next_state == S_ANO);
        error_d   = Error || timeout;
        idx_d     = AnodeIdx;
        if (state == S_DWELL && next_state == S_IDLE)
            idx_d = last_idx ? '0 : AnodeIdx + IDX_W'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            AnodeIdx     <= '0;
            AnodeSel     <= ANODES'(1);
            CathodeData  <= '0;
            shadow       <= '0;
            Clear        <= 1'b0;
            WriteAnode   <= 1'b0;
            WriteCathode <= 1'b0;
            FrameStart   <= 1'b0;
            Busy         <= 1'b0;
            Error        <= 1'b0;
            dwell_cnt    <= '0;
            to_cnt       <= '0;
        end else begin
            AnodeIdx     <= idx_d;
            AnodeSel     <= ANODES'(1) << idx_d;
            Clear        <= clear_d;
            WriteAnode   <= wa_d;
            WriteCathode <= wc_d;
            FrameStart   <= fs_d;
            Busy         <= busy_d;
            Error        <= error_d;
            if (snap)      shadow      <= Data;
            if (load_cath) CathodeData <= disp[AnodeIdx];
            if (in_wait && next_state == state) to_cnt <= to_cnt + TO_W'(1);
            else                                to_cnt <= '0;
            if (state == S_DWELL && Tick)
                dwell_cnt <= dwell_done ? '0 : dwell_cnt + DW_W'(1);
        end
    end
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: scoreboard of expected (index, cathode) pairs
// popped on every cathode strobe, plus handshake, timeout, enable-drop and reset steps.
module tb_display_scanner;
    localparam int ANODES   = 10;
    localparam int GROUPS   = 2;
    localparam int DIGIT_W  = 4;
    localparam int DWELL    = 3;
    localparam int READY_TO = 255;
    localparam int IDX_W    = $clog2(ANODES);
    localparam int GW       = GROUPS * DIGIT_W;
    localparam int TOT      = ANODES * GW;

    typedef logic [IDX_W+GW-1:0] exp_t;

    logic               Clk = 1'b0, Rst = 1'b0, Tick = 1'b0, Enable = 1'b0, Ready = 1'b1;
    logic [TOT-1:0]     Data = '0;
    logic [IDX_W-1:0]   AnodeIdx;
    logic [ANODES-1:0]  AnodeSel;
    logic [GW-1:0]      CathodeData;
    logic               Clear, WriteAnode, WriteCathode, FrameStart, Busy, Error;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, strobes = 0, fs_count = 0;

    display_scanner #(
        .ANODES(ANODES), .GROUPS(GROUPS), .DIGIT_W(DIGIT_W), .DWELL(DWELL),
        .BLANK_LZ(1), .READY_TO(READY_TO)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Tick(Tick), .Enable(Enable), .Data(Data), .Ready(Ready),
        .AnodeIdx(AnodeIdx), .AnodeSel(AnodeSel), .CathodeData(CathodeData),
        .Clear(Clear), .WriteAnode(WriteAnode), .WriteCathode(WriteCathode),
        .FrameStart(FrameStart), .Busy(Busy), .Error(Error)
    );

    always #5 Clk = ~Clk;

    initial begin
        forever begin
            repeat (7) @(negedge Clk);
            Tick = 1'b1;
            @(negedge Clk);
            Tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected digits: locate the highest nonzero digit per group, blank everything above it.
    function automatic logic [GW-1:0] model_cath(input logic [TOT-1:0] d, input int k);
        logic [GW-1:0] r;
        int hi;
        r = '0;
        for (int g = 0; g < GROUPS; g++) begin
            hi = 0;
            for (int j = 0; j < ANODES; j++)
                if (d[(j*GROUPS+g)*DIGIT_W +: DIGIT_W] != '0) hi = j;
            r[g*DIGIT_W +: DIGIT_W] = (k > hi) ? {DIGIT_W{1'b1}} : d[(k*GROUPS+g)*DIGIT_W +: DIGIT_W];
        end
        return r;
    endfunction

    task automatic push_range(input logic [TOT-1:0] d, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) sb.push_back({IDX_W'(k), model_cath(d, k)});
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin @(negedge Clk); c++; end
        check("scoreboard_drained", 64'(sb.size()), 0);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (Busy !== 1'b0 && c < budget) begin @(negedge Clk); c++; end
        check("idle_reached", Busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_idx"}, AnodeIdx, 0);
        check({tag, "_sel"}, AnodeSel, 1);
        check({tag, "_cath"}, CathodeData, 0);
        check({tag, "_flags"}, {Clear, WriteAnode, WriteCathode, FrameStart, Busy, Error}, 0);
    endtask

    // Monitor: strobe exclusivity and order, scoreboard pops, FrameStart index, AnodeSel tracking.
    initial begin
        int last = 0;
        exp_t e;
        logic [IDX_W-1:0] prev_idx = '0;
        forever begin
            @(negedge Clk);
            if (Clear || WriteAnode || WriteCathode) begin
                check("strobe_onehot", 64'(int'(Clear) + int'(WriteAnode) + int'(WriteCathode)), 1);
                strobes++;
            end
            if (Clear) last = 1;
            if (WriteAnode) begin check("order_anode", 64'(last), 1); last = 2; end
            if (WriteCathode) begin
                check("order_cathode", 64'(last), 2);
                last = 3;
                check("cathode_expected", 64'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("cathode", {AnodeIdx, CathodeData}, e);
                end
            end
            if (FrameStart) begin
                check("framestart_idx0", AnodeIdx, 0);
                fs_count++;
            end
            if (AnodeIdx !== prev_idx) begin
                check("anodesel", AnodeSel, ANODES'(1) << AnodeIdx);
                prev_idx = AnodeIdx;
            end
        end
    end

    initial begin
        logic [TOT-1:0] d1, d2, db, d3, d4;
        int c, s0, f0;
        logic prev_err;

        for (int k = 0; k < ANODES; k++) begin
            d1[(k*GROUPS+0)*DIGIT_W +: DIGIT_W] = DIGIT_W'(k);
            d1[(k*GROUPS+1)*DIGIT_W +: DIGIT_W] = DIGIT_W'(k + 3);
            d2[(k*GROUPS+0)*DIGIT_W +: DIGIT_W] = DIGIT_W'(15 - k);
            d2[(k*GROUPS+1)*DIGIT_W +: DIGIT_W] = DIGIT_W'(k ^ 5);
        end
        db = '0;
        db[(6*GROUPS+0)*DIGIT_W +: DIGIT_W] = 4'd7;
        d3 = {$urandom, $urandom, $urandom};
        d4 = {$urandom, $urandom, $urandom};
        d4[TOT-1 -: 2*GW] = '0;

        #1 Rst = 1'b1;
        @(negedge Clk);
        check_reset_outputs("reset");
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_outputs("post_release");

        // Scan with snapshot; data changes while index 4 is showing.
        Data = d1;
        Enable = 1'b1;
        push_range(d1, 0, 9);
        c = 0;
        while (AnodeIdx !== IDX_W'(4) && c < 400) begin @(negedge Clk); c++; end
        check("reached_idx4", AnodeIdx, 4);
        Data = d2;
        push_range(d2, 0, 9);
        wait_drain(1200);
        Enable = 1'b0;
        wait_idle(200);
        check("wrap_idx0", AnodeIdx, 0);
        check("framestart_count", 64'(fs_count), 2);

        // Leading-zero blanking.
        Data = db;
        Enable = 1'b1;
        push_range(db, 0, 9);
        wait_drain(800);
        Enable = 1'b0;
        wait_idle(200);

        // Ready timeout in ANO_W at index 3 with Enable dropped there.
        Data = d3;
        Enable = 1'b1;
        push_range(d3, 0, 3);
        c = 0;
        while (!(WriteAnode === 1'b1 && AnodeIdx === IDX_W'(3)) && c < 400) begin @(negedge Clk); c++; end
        check("anode_strobe_idx3", {WriteAnode, AnodeIdx}, {1'b1, IDX_W'(3)});
        Ready = 1'b0;
        Enable = 1'b0;
        c = 0;
        prev_err = Error;
        while (WriteCathode !== 1'b1 && c < 600) begin prev_err = Error; @(negedge Clk); c++; end
        check("timeout_cycles", 64'(c), READY_TO + 1);
        check("error_before_timeout", prev_err, 0);
        check("error_set", Error, 1);
        Ready = 1'b1;
        wait_idle(200);
        check("idx_after_disable", AnodeIdx, 4);
        s0 = strobes;
        repeat (60) @(negedge Clk);
        check("no_strobes_disabled", 64'(strobes), 64'(s0));
        check("error_sticky", Error, 1);

        // Reset during CAT_W aborts the digit.
        Enable = 1'b1;
        push_range(d3, 4, 4);
        c = 0;
        while (!(WriteCathode === 1'b1 && AnodeIdx === IDX_W'(4)) && c < 200) begin @(negedge Clk); c++; end
        check("cathode_strobe_idx4", {WriteCathode, AnodeIdx}, {1'b1, IDX_W'(4)});
        @(negedge Clk);
        Rst = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        Enable = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        s0 = strobes;
        repeat (40) @(negedge Clk);
        check("no_strobes_after_reset", 64'(strobes), 64'(s0));
        Data = d4;
        f0 = fs_count;
        Enable = 1'b1;
        push_range(d4, 0, 9);
        wait_drain(800);
        check("framestart_after_reset", 64'(fs_count), 64'(f0 + 1));
        Enable = 1'b0;
        wait_idle(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
